blink_checker: RTL and testbench

// - Receive-side monitor for the blinker's led/flg outputs. Checks that flg pulses

---
 rtl/blink_checker.sv | 174 +++++++++++++++++
 tb/tb_blink_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/blink_checker.sv
// Receive-side monitor for a blinker: verifies the flg pulse interval and that
// led toggles LED_LAG cycles after each flg pulse; reports lock and error pulses.
module blink_checker #(
  parameter int CBITS    = 26,
  parameter int LOCK_CNT = 2,
  parameter int LED_LAG  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flg_in,
  input  logic             led_in,
  output logic             locked,
  output logic             err_period,
  output logic             err_led,
  output logic             err_sticky,
  output logic [CBITS:0]   period_meas
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int              GW       = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CBITS:0]  PERIOD   = {1'b1, {CBITS{1'b0}}};
  localparam logic [GW-1:0]   LOCK_TGT = GW'(LOCK_CNT);

  state_e               state_q, state_d;
  logic [CBITS:0]       icnt_q, icnt_d;
  logic [GW-1:0]        good_q, good_d;
  logic                 led_prev_q;
  logic [LED_LAG-1:0]   dly_q, dly_d;
  logic                 locked_q, locked_d;
  logic                 err_period_q, err_period_d;
  logic                 err_led_q, err_led_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [CBITS:0]       period_meas_q, period_meas_d;

  logic [CBITS:0]       interval_s;
  logic [GW-1:0]        good_inc_s;
  logic                 toggled_s;
  logic                 exp_toggle_s;

  // Next-state, interval measurement and error decode.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    period_meas_d = period_meas_q;
    err_period_d  = 1'b0;
    err_led_d     = 1'b0;
    interval_s    = icnt_q + {{CBITS{1'b0}}, 1'b1};
    good_inc_s    = good_q + {{(GW-1){1'b0}}, 1'b1};
    toggled_s     = led_in ^ led_prev_q;
    exp_toggle_s  = dly_q[LED_LAG-1];

    case (state_q)
      HUNT: begin
        if (flg_in) begin
          state_d = MEASURE;
          good_d  = {GW{1'b0}};
        end else begin
          state_d = HUNT;
        end
      end
      MEASURE: begin
        if (flg_in) begin
          period_meas_d = interval_s;
          if (interval_s == PERIOD) begin
            good_d = good_inc_s;
            if (good_inc_s == LOCK_TGT) begin
              state_d = LOCKED;
            end else begin
              state_d = MEASURE;
            end
          end else begin
            err_period_d = 1'b1;
            good_d       = {GW{1'b0}};
          end
        end else if (icnt_q == PERIOD) begin
          // The interval would reach PERIOD+1: the pulse is missing.
          err_period_d = 1'b1;
          good_d       = {GW{1'b0}};
          state_d      = HUNT;
        end else begin
          state_d = MEASURE;
        end
      end
      LOCKED: begin
        if (flg_in) begin
          period_meas_d = interval_s;
          if (interval_s != PERIOD) begin
            err_period_d = 1'b1;
            good_d       = {GW{1'b0}};
            state_d      = MEASURE;
          end else begin
            state_d = LOCKED;
          end
        end else if (icnt_q == PERIOD) begin
          err_period_d = 1'b1;
          good_d       = {GW{1'b0}};
          state_d      = HUNT;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = {GW{1'b0}};
      end
    endcase

    if (state_q != HUNT) begin
      err_led_d = exp_toggle_s ? ~toggled_s : toggled_s;
    end else begin
      err_led_d = 1'b0;
    end

    if (flg_in || (state_d == HUNT)) begin
      icnt_d = {(CBITS+1){1'b0}};
    end else begin
      icnt_d = icnt_q + {{CBITS{1'b0}}, 1'b1};
    end

    // Marks still in flight are dropped whenever the monitor falls back to HUNT.
    dly_d    = dly_q;
    dly_d[0] = flg_in;
    for (int i = 1; i < LED_LAG; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    if (state_d == HUNT) begin
      dly_d = {LED_LAG{1'b0}};
    end else begin
      dly_d = dly_d;
    end

    locked_d     = (state_d == LOCKED);
    err_sticky_d = err_sticky_q | err_period_d | err_led_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      icnt_q        <= {(CBITS+1){1'b0}};
      good_q        <= {GW{1'b0}};
      led_prev_q    <= 1'b0;
      dly_q         <= {LED_LAG{1'b0}};
      locked_q      <= 1'b0;
      err_period_q  <= 1'b0;
      err_led_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      period_meas_q <= {(CBITS+1){1'b0}};
    end else begin
      state_q       <= state_d;
      icnt_q        <= icnt_d;
      good_q        <= good_d;
      led_prev_q    <= led_in;
      dly_q         <= dly_d;
      locked_q      <= locked_d;
      err_period_q  <= err_period_d;
      err_led_q     <= err_led_d;
      err_sticky_q  <= err_sticky_d;
      period_meas_q <= period_meas_d;
    end
  end

  assign locked      = locked_q;
  assign err_period  = err_period_q;
  assign err_led     = err_led_q;
  assign err_sticky  = err_sticky_q;
  assign period_meas = period_meas_q;

endmodule

// File: tb/tb_blink_checker.sv
// Directed bench for blink_checker with CBITS=3 (PERIOD=8), LOCK_CNT=2, LED_LAG=1.
module tb_blink_checker;

  localparam int CBITS = 3;

  logic             clk;
  logic             rst;
  logic             flg_in;
  logic             led_in;
  logic             locked;
  logic             err_period;
  logic             err_led;
  logic             err_sticky;
  logic [CBITS:0]   period_meas;

  int checks   = 0;
  int failures = 0;
  int cnt_ep   = 0;
  int cnt_el   = 0;
  logic led_v  = 1'b0;

  blink_checker #(.CBITS(CBITS), .LOCK_CNT(2), .LED_LAG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flg_in      (flg_in),
    .led_in      (led_in),
    .locked      (locked),
    .err_period  (err_period),
    .err_led     (err_led),
    .err_sticky  (err_sticky),
    .period_meas (period_meas)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic l);
    flg_in = f;
    led_in = l;
    @(posedge clk);
    #1;
    cnt_ep += int'(err_period);
    cnt_el += int'(err_led);
  endtask

  task automatic flg();
    cyc(1'b1, led_v);
  endtask

  // n-1 idle cycles after a flg pulse, toggling led on cycle index lag.
  task automatic rest(input int n, input int lag);
    for (int i = 1; i < n; i++) begin
      if (i == lag) led_v = ~led_v;
      cyc(1'b0, led_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    flg_in = 1'b0;
    led_in = 1'b0;
    cyc(1'b0, led_v);
    cyc(1'b0, led_v);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_period", {31'd0, err_period}, 32'd0);
    chk("rst_err_led", {31'd0, err_led}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_meas", {28'd0, period_meas}, 32'd0);
    rst = 1'b0;
    cnt_ep = 0;
    cnt_el = 0;

    // Clean lock-in
    flg(); rest(8, 1);
    flg();
    chk("clean2_meas", {28'd0, period_meas}, 32'd8);
    chk("clean2_locked", {31'd0, locked}, 32'd0);
    rest(8, 1);
    flg();
    chk("clean3_locked", {31'd0, locked}, 32'd1);
    chk("clean3_meas", {28'd0, period_meas}, 32'd8);
    chk("clean_no_err", cnt_ep + cnt_el, 32'd0);
    rest(8, 1);

    // Short interval while locked
    flg(); rest(7, 1);
    flg();
    chk("short_err", {31'd0, err_period}, 32'd1);
    chk("short_meas", {28'd0, period_meas}, 32'd7);
    chk("short_locked", {31'd0, locked}, 32'd0);
    chk("short_sticky", {31'd0, err_sticky}, 32'd1);
    rest(8, 1);
    flg();
    chk("relock1_locked", {31'd0, locked}, 32'd0);
    chk("relock1_err", {31'd0, err_period}, 32'd0);
    rest(8, 1);
    flg();
    chk("relock2_locked", {31'd0, locked}, 32'd1);

    // Late led toggle
    rest(8, 2);
    chk("late_led_cnt", cnt_el, 32'd2);
    chk("late_ep_cnt", cnt_ep, 32'd1);
    flg();
    chk("late_locked", {31'd0, locked}, 32'd1);
    chk("late_meas", {28'd0, period_meas}, 32'd8);
    rest(8, 1);

    // Missing pulse
    cyc(1'b0, led_v);
    chk("miss_int8", {31'd0, err_period}, 32'd0);
    cyc(1'b0, led_v);
    chk("miss_int9", {31'd0, err_period}, 32'd1);
    chk("miss_locked", {31'd0, locked}, 32'd0);
    led_v = ~led_v;
    cyc(1'b0, led_v);
    chk("hunt_led_ignored", {31'd0, err_led}, 32'd0);

    // flg held two cycles in MEASURE
    flg();
    led_v = ~led_v;
    cyc(1'b1, led_v);
    chk("dbl_err", {31'd0, err_period}, 32'd1);
    chk("dbl_meas", {28'd0, period_meas}, 32'd1);
    chk("dbl_err_led", {31'd0, err_led}, 32'd0);
    rest(8, 1);
    chk("dbl_el_cnt", cnt_el, 32'd2);
    chk("dbl_ep_cnt", cnt_ep, 32'd3);
    flg();
    chk("dbl_good_reset", {31'd0, locked}, 32'd0);
    rest(8, 1);
    flg();
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    rest(4, 1);

    // Reset mid-LOCKED
    rst = 1'b1;
    cyc(1'b0, led_v);
    rst = 1'b0;
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("mid_rst_meas", {28'd0, period_meas}, 32'd0);
    chk("mid_rst_ep", {31'd0, err_period}, 32'd0);
    rest(3, 0);
    flg(); rest(8, 1);
    flg();
    chk("post_rst_locked2", {31'd0, locked}, 32'd0);
    rest(8, 1);
    flg();
    chk("post_rst_locked3", {31'd0, locked}, 32'd1);
    chk("post_rst_meas", {28'd0, period_meas}, 32'd8);
    rest(8, 1);
    chk("post_rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("final_ep_cnt", cnt_ep, 32'd3);
    chk("final_el_cnt", cnt_el, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
